// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory port bundle for load_store_unit
interface load_store_unit_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              mem_write_enable;
  logic              mem_read_enable;

  // The access controller's view: consumes requests, produces responses, drives the memory port.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_address, mem_write_data, mem_write_enable, mem_read_enable,
    input  mem_read_data
  );

  // The environment's view: execute stage issuing requests plus the data memory itself.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_address, mem_write_data, mem_write_enable, mem_read_enable,
    output mem_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store controller with RMW sub-word stores (optional MISALIGN_TRAP_EN alignment trap)
module load_store_unit #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_t            state;
  state_t            nextState;

  logic              isWrite;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       mergeWord;
  logic [31:0]       rdata;
  logic              err;

  logic              funct3Ok;
  logic              rangeOk;
  logic              alignOk;
  logic              reqOk;
  logic [31:0]       loadExt;
  logic [31:0]       mergeNext;

  // Validate the incoming request so IDLE can both latch and branch on the accept edge.
  always_comb begin
    funct3Ok = 1'b0;
    if (bus.req_write) begin
      funct3Ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      funct3Ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    rangeOk = (bus.req_addr <= LAST_ADDR);
    alignOk = 1'b1;
`ifdef MISALIGN_TRAP_EN
    // funct3[1:0] 01 covers H/HU/SH, 10 covers W/SW.
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0] != 1'b0) begin
      alignOk = 1'b0;
    end
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) begin
      alignOk = 1'b0;
    end
`endif
    reqOk = funct3Ok && rangeOk && alignOk;
  end

  // Extend the memory word for loads and splice store data into it for sub-word stores.
  always_comb begin
    case (funct3)
      3'b000:  loadExt = {{24{bus.mem_read_data[7]}}, bus.mem_read_data[7:0]};
      3'b001:  loadExt = {{16{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      3'b100:  loadExt = {24'h0, bus.mem_read_data[7:0]};
      3'b101:  loadExt = {16'h0, bus.mem_read_data[15:0]};
      default: loadExt = bus.mem_read_data;
    endcase
    if (funct3[0]) begin
      mergeNext = {bus.mem_read_data[31:16], wdata[15:0]};
    end else begin
      mergeNext = {bus.mem_read_data[31:8], wdata[7:0]};
    end
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Datapath registers: request latch, merge word, load result and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isWrite   <= 1'b0;
      funct3    <= 3'b000;
      addr      <= '0;
      wdata     <= 32'h0;
      mergeWord <= 32'h0;
      rdata     <= 32'h0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            isWrite <= bus.req_write;
            funct3  <= bus.req_funct3;
            addr    <= bus.req_addr;
            wdata   <= bus.req_wdata;
            rdata   <= 32'h0;
            err     <= ~reqOk;
          end
        end
        LOAD:     rdata     <= loadExt;
        RMW_READ: mergeWord <= mergeNext;
        default: ;
      endcase
    end
  end

  // Next-state and output decode; enables come straight from state so reset kills them at once.
  always_comb begin
    nextState            = state;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_rdata       = 32'h0;
    bus.resp_err         = 1'b0;
    bus.mem_address      = '0;
    bus.mem_write_data   = 32'h0;
    bus.mem_write_enable = 1'b0;
    bus.mem_read_enable  = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (!reqOk) begin
            nextState = RESP;
          end else if (!bus.req_write) begin
            nextState = LOAD;
          end else if (bus.req_funct3 == 3'b010) begin
            nextState = WRITE;
          end else begin
            nextState = RMW_READ;
          end
        end
      end
      LOAD: begin
        bus.mem_read_enable = 1'b1;
        bus.mem_address     = addr;
        nextState           = RESP;
      end
      RMW_READ: begin
        bus.mem_read_enable = 1'b1;
        bus.mem_address     = addr;
        nextState           = WRITE;
      end
      WRITE: begin
        bus.mem_write_enable = 1'b1;
        bus.mem_address      = addr;
        bus.mem_write_data   = funct3[1] ? wdata : mergeWord;
        nextState            = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = (isWrite || err) ? 32'h0 : rdata;
        bus.resp_err   = err;
        if (bus.resp_ready) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule
